// File: rtl/ns_arb_2to1_pkg.sv
// Shared definitions for the ns_arb_2to1 message arbiter: default channel field
// widths, FSM state encoding and the round-robin pick helper.
// Optional build macro used by the arbiter: NS_ARB_REDUN_CHECK_EN.
package ns_arb_2to1_pkg;

  // Default channel field widths
  localparam int unsigned NsAddressSize = 8;
  localparam int unsigned NsDataSize    = 16;
  localparam int unsigned NsRedunSize   = 8;

  // Arbiter FSM states (3-bit encoding)
  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StCheck   = 3'd1,
    StSend    = 3'd2,
    StDrain   = 3'd3,
    StRelease = 3'd4
  } arb_state_e;

  // Round-robin pick between two eligible inputs. When both are eligible the
  // priority pointer decides; otherwise the single eligible input wins.
  // The result is only meaningful when at least one input is eligible.
  function automatic logic rr_pick(input logic elig0, input logic elig1, input logic prio);
    logic pick;
    if (elig0 && elig1) begin
      pick = prio;
    end else if (elig1) begin
      pick = 1'b1;
    end else begin
      pick = 1'b0;
    end
    return pick;
  endfunction

endpackage

// File: rtl/ns_arb_2to1_calc_redun.sv
// Redundancy generator for one message: XOR-folds the concatenation
// {src, dst, dat} into RSZ bits, so bit r of the result is the parity of every
// message bit whose position is congruent to r modulo RSZ.
// Instantiated by ns_arb_2to1 only when NS_ARB_REDUN_CHECK_EN is defined.
module ns_arb_2to1_calc_redun
  import ns_arb_2to1_pkg::*;
#(
  parameter int unsigned ASZ = NsAddressSize,
  parameter int unsigned DSZ = NsDataSize,
  parameter int unsigned RSZ = NsRedunSize
) (
  input  logic [ASZ-1:0] src_i,
  input  logic [ASZ-1:0] dst_i,
  input  logic [DSZ-1:0] dat_i,
  output logic [RSZ-1:0] red_o
);

  localparam int unsigned MsgW = 2 * ASZ + DSZ;

  // Mask selecting the message bits that fold into redundancy bit r
  function automatic logic [MsgW-1:0] fold_mask(input int unsigned r);
    logic [MsgW-1:0] m;
    logic [MsgW-1:0] one;
    m   = '0;
    one = {{(MsgW-1){1'b0}}, 1'b1};
    for (int unsigned i = r; i < MsgW; i += RSZ) begin
      m = m | (one << i);
    end
    return m;
  endfunction

  logic [MsgW-1:0] msg;

  assign msg = {src_i, dst_i, dat_i};

  for (genvar r = 0; r < RSZ; r++) begin : g_fold
    localparam logic [MsgW-1:0] Mask = fold_mask(r);
    assign red_o[r] = ^(msg & Mask);
  end

endmodule

// File: rtl/ns_arb_2to1.sv
// Two-input, one-output round-robin arbiter for the 4-phase message channel.
// A granted message is latched whole into the output registers, optionally
// checked against its redundancy field, then forwarded to the shared sink.
// Build option: define NS_ARB_REDUN_CHECK_EN to drop messages whose red field
// does not match and flag them on the sticky arb_err output. Without it the
// check stage always passes (same latency) and arb_err is constant 0.
module ns_arb_2to1
  import ns_arb_2to1_pkg::*;
#(
  parameter int unsigned ASZ = NsAddressSize,
  parameter int unsigned DSZ = NsDataSize,
  parameter int unsigned RSZ = NsRedunSize
) (
  input  logic           clk,
  input  logic           reset,
  // Channel 0
  input  logic [ASZ-1:0] i0_src,
  input  logic [ASZ-1:0] i0_dst,
  input  logic [DSZ-1:0] i0_dat,
  input  logic [RSZ-1:0] i0_red,
  input  logic           i0_req,
  output logic           i0_ack,
  // Channel 1
  input  logic [ASZ-1:0] i1_src,
  input  logic [ASZ-1:0] i1_dst,
  input  logic [DSZ-1:0] i1_dat,
  input  logic [RSZ-1:0] i1_red,
  input  logic           i1_req,
  output logic           i1_ack,
  // Output channel
  output logic [ASZ-1:0] o0_src,
  output logic [ASZ-1:0] o0_dst,
  output logic [DSZ-1:0] o0_dat,
  output logic [RSZ-1:0] o0_red,
  output logic           o0_req,
  input  logic           o0_ack,
  // Status
  output logic           arb_gnt,
  output logic           arb_err
);

  arb_state_e     state_q, state_d;
  logic           prio_q, prio_d;  // input that wins a tie on the next grant
  logic           gnt_q, gnt_d;
  logic           err_q, err_d;
  logic           ack0_q, ack0_d;
  logic           ack1_q, ack1_d;
  logic           oreq_q, oreq_d;
  logic [ASZ-1:0] src_q, src_d;
  logic [ASZ-1:0] dst_q, dst_d;
  logic [DSZ-1:0] dat_q, dat_d;
  logic [RSZ-1:0] red_q, red_d;

  logic elig0, elig1;
  logic sel;
  logic gnt_req;
  logic red_ok;

  // An input is eligible while it requests and has not yet been acknowledged
  assign elig0 = i0_req & ~ack0_q;
  assign elig1 = i1_req & ~ack1_q;

  // Request of the currently granted input, watched in RELEASE
  assign gnt_req = gnt_q ? i1_req : i0_req;

`ifdef NS_ARB_REDUN_CHECK_EN
  logic [RSZ-1:0] calc_red;

  ns_arb_2to1_calc_redun #(
    .ASZ(ASZ),
    .DSZ(DSZ),
    .RSZ(RSZ)
  ) u_calc_redun (
    .src_i(src_q),
    .dst_i(dst_q),
    .dat_i(dat_q),
    .red_o(calc_red)
  );

  assign red_ok = (calc_red == red_q);
`else
  assign red_ok = 1'b1;
`endif

  // Next-state logic: arbitration, message latch and handshake sequencing
  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    gnt_d   = gnt_q;
    err_d   = err_q;
    ack0_d  = ack0_q;
    ack1_d  = ack1_q;
    oreq_d  = oreq_q;
    src_d   = src_q;
    dst_d   = dst_q;
    dat_d   = dat_q;
    red_d   = red_q;
    sel     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (elig0 || elig1) begin
          sel     = rr_pick(elig0, elig1, prio_q);
          gnt_d   = sel;
          prio_d  = ~sel;
          src_d   = sel ? i1_src : i0_src;
          dst_d   = sel ? i1_dst : i0_dst;
          dat_d   = sel ? i1_dat : i0_dat;
          red_d   = sel ? i1_red : i0_red;
          state_d = StCheck;
        end
      end

      StCheck: begin
        if (red_ok) begin
          oreq_d  = 1'b1;
          state_d = StSend;
        end else begin
          // Corrupted message: complete the input handshake without forwarding
          err_d   = 1'b1;
          ack0_d  = ~gnt_q;
          ack1_d  = gnt_q;
          state_d = StRelease;
        end
      end

      StSend: begin
        if (o0_ack) begin
          oreq_d  = 1'b0;
          state_d = StDrain;
        end
      end

      StDrain: begin
        if (!o0_ack) begin
          ack0_d  = ~gnt_q;
          ack1_d  = gnt_q;
          state_d = StRelease;
        end
      end

      StRelease: begin
        if (!gnt_req) begin
          ack0_d  = 1'b0;
          ack1_d  = 1'b0;
          state_d = StIdle;
        end
      end

      default: begin
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        oreq_d  = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  // State and output registers with synchronous active-high reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      prio_q  <= 1'b0;
      gnt_q   <= 1'b0;
      err_q   <= 1'b0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      oreq_q  <= 1'b0;
      src_q   <= '0;
      dst_q   <= '0;
      dat_q   <= '0;
      red_q   <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      gnt_q   <= gnt_d;
      err_q   <= err_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      oreq_q  <= oreq_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      dat_q   <= dat_d;
      red_q   <= red_d;
    end
  end

  assign i0_ack  = ack0_q;
  assign i1_ack  = ack1_q;
  assign o0_req  = oreq_q;
  assign o0_src  = src_q;
  assign o0_dst  = dst_q;
  assign o0_dat  = dat_q;
  assign o0_red  = red_q;
  assign arb_gnt = gnt_q;
  assign arb_err = err_q;

endmodule

// File: tb/tb_ns_arb_2to1.sv
// Self-checking bench for ns_arb_2to1 (default widths 8/8/16/8). Expected
// messages are queued when producers are started and compared by the sink
// process when the arbiter presents them on the output channel.
module tb_ns_arb_2to1;

  typedef struct packed {
    logic [7:0]  src;
    logic [7:0]  dst;
    logic [15:0] dat;
    logic [7:0]  red;
    logic        gnt;
  } exp_t;

  logic        clk;
  logic        reset;
  logic [7:0]  i0_src, i0_dst, i1_src, i1_dst;
  logic [15:0] i0_dat, i1_dat;
  logic [7:0]  i0_red, i1_red;
  logic        i0_req, i1_req, i0_ack, i1_ack;
  logic [7:0]  o0_src, o0_dst;
  logic [15:0] o0_dat;
  logic [7:0]  o0_red;
  logic        o0_req, o0_ack;
  logic        arb_gnt, arb_err;

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];
  bit   sink_en = 1'b1;
  int   sink_delay = 0;

  ns_arb_2to1 dut (
    .clk    (clk),
    .reset  (reset),
    .i0_src (i0_src),
    .i0_dst (i0_dst),
    .i0_dat (i0_dat),
    .i0_red (i0_red),
    .i0_req (i0_req),
    .i0_ack (i0_ack),
    .i1_src (i1_src),
    .i1_dst (i1_dst),
    .i1_dat (i1_dat),
    .i1_red (i1_red),
    .i1_req (i1_req),
    .i1_ack (i1_ack),
    .o0_src (o0_src),
    .o0_dst (o0_dst),
    .o0_dat (o0_dat),
    .o0_red (o0_red),
    .o0_req (o0_req),
    .o0_ack (o0_ack),
    .arb_gnt(arb_gnt),
    .arb_err(arb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference redundancy: byte-wise XOR of {src, dst, dat}
  function automatic logic [7:0] red_model(input logic [7:0] s, input logic [7:0] d,
                                           input logic [15:0] t);
    return s ^ d ^ t[15:8] ^ t[7:0];
  endfunction

  function automatic exp_t mk(input logic [7:0] s, input logic [7:0] d, input logic [15:0] t,
                              input logic g);
    exp_t e;
    e.src = s;
    e.dst = d;
    e.dat = t;
    e.red = red_model(s, d, t);
    e.gnt = g;
    return e;
  endfunction

  // Sink: compares each presented message with the scoreboard, then acks
  initial begin : sink
    exp_t e;
    int   n;
    o0_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (sink_en && o0_req === 1'b1) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL sink_unexpected: o0_req=1 with src=%0d dst=%0d dat=%0d, required no message",
                   o0_src, o0_dst, o0_dat);
          @(negedge clk);
        end else begin
          e = sb_q.pop_front();
          if ({o0_src, o0_dst, o0_dat, o0_red, arb_gnt} !== e) begin
            errors++;
            $display("FAIL sink_msg: got src=%0d dst=%0d dat=%0d red=%0h gnt=%0d, required src=%0d dst=%0d dat=%0d red=%0h gnt=%0d",
                     o0_src, o0_dst, o0_dat, o0_red, arb_gnt, e.src, e.dst, e.dat, e.red, e.gnt);
          end
          for (int k = 0; k < sink_delay; k++) begin
            @(negedge clk);
            checks++;
            if ({o0_req, o0_src, o0_dst, o0_dat, o0_red, i0_ack, i1_ack} !==
                {1'b1, e.src, e.dst, e.dat, e.red, 1'b0, 1'b0}) begin
              errors++;
              $display("FAIL sink_stall cycle %0d: req=%0d src=%0d dst=%0d dat=%0d red=%0h acks=%0d%0d, required req=1 src=%0d dst=%0d dat=%0d red=%0h acks=00",
                       k, o0_req, o0_src, o0_dst, o0_dat, o0_red, i0_ack, i1_ack,
                       e.src, e.dst, e.dat, e.red);
            end
          end
          o0_ack = 1'b1;
          for (n = 0; n < 10; n++) begin
            @(negedge clk);
            if (o0_req === 1'b0) break;
          end
          checks++;
          if (n == 10) begin
            errors++;
            $display("FAIL sink_req_drop: o0_req=%0d after o0_ack, required 0", o0_req);
          end
          o0_ack = 1'b0;
        end
      end
    end
  end

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Producer: full 4-phase handshake on one input channel, bounded waits
  task automatic produce(input bit ch, input exp_t m, input int bound);
    int n;
    if (ch) begin
      i1_src = m.src; i1_dst = m.dst; i1_dat = m.dat; i1_red = m.red; i1_req = 1'b1;
    end else begin
      i0_src = m.src; i0_dst = m.dst; i0_dat = m.dat; i0_red = m.red; i0_req = 1'b1;
    end
    for (n = 0; n < bound; n++) begin
      @(negedge clk);
      if ((ch ? i1_ack : i0_ack) === 1'b1) break;
    end
    checks++;
    if (n == bound) begin
      errors++;
      $display("FAIL ack_rise ch%0d dat=%0d: ack=0 after %0d cycles, required 1", ch, m.dat, bound);
    end
    if (ch) i1_req = 1'b0;
    else i0_req = 1'b0;
    for (n = 0; n < 10; n++) begin
      @(negedge clk);
      if ((ch ? i1_ack : i0_ack) === 1'b0) break;
    end
    checks++;
    if (n == 10) begin
      errors++;
      $display("FAIL ack_fall ch%0d: ack=1 after req dropped, required 0", ch);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    i0_src = 8'd1; i0_dst = 8'd2; i0_dat = 16'd3; i0_red = 8'd4; i0_req = 1'b1;
    i1_src = 8'd5; i1_dst = 8'd6; i1_dat = 16'd7; i1_red = 8'd8; i1_req = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({i0_ack, i1_ack, o0_req, arb_gnt, arb_err} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: acks=%0d%0d o0_req=%0d gnt=%0d err=%0d, required all 0",
               i0_ack, i1_ack, o0_req, arb_gnt, arb_err);
    end
    checks++;
    if ({o0_src, o0_dst, o0_dat, o0_red} !== 40'd0) begin
      errors++;
      $display("FAIL reset_fields: src=%0d dst=%0d dat=%0d red=%0d, required all 0",
               o0_src, o0_dst, o0_dat, o0_red);
    end
    @(negedge clk);
    i0_req = 1'b0;
    i1_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_single();
    exp_t m;
    int   n;
    do_reset();
    m = mk(8'd9, 8'd10, 16'd5, 1'b0);
    sb_q.push_back(m);
    i0_src = m.src; i0_dst = m.dst; i0_dat = m.dat; i0_red = m.red; i0_req = 1'b1;
    @(negedge clk);
    checks++;
    if (o0_req !== 1'b0) begin
      errors++;
      $display("FAIL single_lat1: o0_req=%0d one cycle after req, required 0", o0_req);
    end
    @(negedge clk);
    checks++;
    if (o0_req !== 1'b1) begin
      errors++;
      $display("FAIL single_lat2: o0_req=%0d two cycles after req, required 1", o0_req);
    end
    checks++;
    if (o0_dat !== 16'd5 || arb_gnt !== 1'b0) begin
      errors++;
      $display("FAIL single_data: o0_dat=%0d gnt=%0d, required 5 and 0", o0_dat, arb_gnt);
    end
    for (n = 0; n < 10; n++) begin
      @(negedge clk);
      if (i0_ack === 1'b1) break;
    end
    checks++;
    if (n == 10 || o0_ack !== 1'b0 || o0_req !== 1'b0) begin
      errors++;
      $display("FAIL single_ack: i0_ack=%0d o0_ack=%0d o0_req=%0d, required 1 0 0",
               i0_ack, o0_ack, o0_req);
    end
    i0_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (i0_ack !== 1'b0) begin
      errors++;
      $display("FAIL single_release: i0_ack=%0d, required 0", i0_ack);
    end
  endtask

  task automatic test_round_robin();
    exp_t a, b;
    do_reset();
    for (int r = 0; r < 4; r++) begin
      a = mk(8'(16 * r + 1), 8'(16 * r + 2), 16'(256 * r + 17), 1'b0);
      b = mk(8'(16 * r + 3), 8'(16 * r + 4), 16'(256 * r + 34), 1'b1);
      sb_q.push_back(a);
      sb_q.push_back(b);
      @(negedge clk);
      fork
        produce(1'b0, a, 40);
        produce(1'b1, b, 40);
      join
    end
  endtask

  task automatic test_i1_only();
    exp_t m;
    for (int k = 1; k <= 3; k++) begin
      m = mk(8'd20, 8'd21, 16'(k), 1'b1);
      sb_q.push_back(m);
      produce(1'b1, m, 8);
    end
  endtask

  task automatic test_sink_stall();
    exp_t m;
    sink_delay = 20;
    m = mk(8'd33, 8'd44, 16'hBEEF, 1'b0);
    sb_q.push_back(m);
    @(negedge clk);
    produce(1'b0, m, 60);
    sink_delay = 0;
  endtask

  task automatic test_redun();
    exp_t m;
    m = mk(8'd3, 8'd4, 16'd77, 1'b0);
    m.red = m.red ^ 8'h01;
`ifdef NS_ARB_REDUN_CHECK_EN
    // Corrupted message must be dropped; the sink flags any forwarded message
    produce(1'b0, m, 20);
    checks++;
    if (arb_err !== 1'b1) begin
      errors++;
      $display("FAIL redun_err: arb_err=%0d after bad message, required 1", arb_err);
    end
    m = mk(8'd5, 8'd6, 16'd99, 1'b0);
    sb_q.push_back(m);
    produce(1'b0, m, 20);
    checks++;
    if (arb_err !== 1'b1) begin
      errors++;
      $display("FAIL redun_sticky: arb_err=%0d after good message, required 1", arb_err);
    end
`else
    // Without the check the message is forwarded untouched and no error flagged
    sb_q.push_back(m);
    produce(1'b0, m, 20);
    checks++;
    if (arb_err !== 1'b0) begin
      errors++;
      $display("FAIL redun_off: arb_err=%0d, required 0", arb_err);
    end
`endif
  endtask

  task automatic test_reset_mid();
    exp_t m;
    int   n;
    sink_en = 1'b0;
    m = mk(8'd70, 8'd71, 16'd72, 1'b0);
    @(negedge clk);
    i0_src = m.src; i0_dst = m.dst; i0_dat = m.dat; i0_red = m.red; i0_req = 1'b1;
    for (n = 0; n < 10; n++) begin
      @(negedge clk);
      if (o0_req === 1'b1) break;
    end
    checks++;
    if (n == 10) begin
      errors++;
      $display("FAIL midreset_send: o0_req=%0d, required 1", o0_req);
    end
    reset = 1'b1;
    i0_req = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({o0_req, i0_ack, i1_ack, arb_err, arb_gnt} !== 5'b0 || o0_dat !== 16'd0) begin
      errors++;
      $display("FAIL midreset_state: o0_req=%0d acks=%0d%0d err=%0d gnt=%0d dat=%0d, required all 0",
               o0_req, i0_ack, i1_ack, arb_err, arb_gnt, o0_dat);
    end
    @(negedge clk);
    reset = 1'b0;
    sink_en = 1'b1;
    sb_q.push_back(m);
    produce(1'b0, m, 10);
  endtask

  initial begin : main
    o0_ack = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_i1_only();
    test_sink_stall();
    test_redun();
    test_reset_mid();
    repeat (5) @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d messages never forwarded, required 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
